// File: rtl/pointwise_add_sched.sv
// Time-multiplexed pointwise vector adder shared by two requesters via round-robin arbitration.
// Optional build macro POINTWISE_ADD_SAT_EN turns per-lane wrap into saturation.
`ifndef MAX_NEURONS
`define MAX_NEURONS 16
`endif

module pointwise_add_sched #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned NUM_ELEM = `MAX_NEURONS,
  parameter int unsigned LANES    = 4,
  parameter int unsigned LEN_W    = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req_a,
  input  logic [LEN_W-1:0]          len_a,
  input  logic [NUM_ELEM*WIDTH-1:0] vec1_a,
  input  logic [NUM_ELEM*WIDTH-1:0] vec2_a,
  input  logic                      req_b,
  input  logic [LEN_W-1:0]          len_b,
  input  logic [NUM_ELEM*WIDTH-1:0] vec1_b,
  input  logic [NUM_ELEM*WIDTH-1:0] vec2_b,
  output logic                      grant_a,
  output logic                      grant_b,
  output logic                      done_a,
  output logic                      done_b,
  output logic                      busy,
  output logic [NUM_ELEM*WIDTH-1:0] out_vec
);

  localparam int unsigned     IDX_W      = (NUM_ELEM > 1) ? $clog2(NUM_ELEM) : 1;
  localparam logic [LEN_W-1:0] NUM_ELEM_L = LEN_W'(NUM_ELEM);
  localparam logic [LEN_W-1:0] LANES_L    = LEN_W'(LANES);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state, w_next;
  logic             r_ptr_b;    // 1: B wins the next contention
  logic             r_owner_b;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_idx;
  logic [WIDTH-1:0] r_op1 [NUM_ELEM];
  logic [WIDTH-1:0] r_op2 [NUM_ELEM];
  logic [WIDTH-1:0] r_res [NUM_ELEM];

  logic             w_take;
  logic             w_pick_b;
  logic [LEN_W-1:0] w_len_raw;
  logic [LEN_W-1:0] w_len_clamp;
  logic [LEN_W-1:0] w_idx_next;
  logic [LEN_W-1:0] w_j   [LANES];
  logic [WIDTH-1:0] w_sum [LANES];

  function automatic logic [WIDTH-1:0] lane_add(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
`ifdef POINTWISE_ADD_SAT_EN
    logic [WIDTH:0] s;
    s = {a[WIDTH-1], a} + {b[WIDTH-1], b};
    if (s[WIDTH] != s[WIDTH-1])
      lane_add = s[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    else
      lane_add = s[WIDTH-1:0];
`else
    lane_add = a + b;
`endif
  endfunction

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Arbitration and next-state
  always_comb begin
    w_next      = r_state;
    w_take      = 1'b0;
    w_pick_b    = req_b & (~req_a | r_ptr_b);
    w_len_raw   = w_pick_b ? len_b : len_a;
    w_len_clamp = (w_len_raw > NUM_ELEM_L) ? NUM_ELEM_L : w_len_raw;
    w_idx_next  = r_idx + LANES_L;
    case (r_state)
      S_IDLE: begin
        if (req_a | req_b) begin
          w_take = 1'b1;
          w_next = (w_len_clamp == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN:   if (w_idx_next >= r_len) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Lane adders; lanes past the valid length produce zero
  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      w_j[k]   = r_idx + LEN_W'(k);
      w_sum[k] = lane_add(r_op1[IDX_W'(w_j[k])], r_op2[IDX_W'(w_j[k])]);
      if (w_j[k] >= r_len) w_sum[k] = '0;
    end
  end

  // Operand capture, chunk processing and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ptr_b   <= 1'b0;
      r_owner_b <= 1'b0;
      r_len     <= '0;
      r_idx     <= '0;
      grant_a   <= 1'b0;
      grant_b   <= 1'b0;
      done_a    <= 1'b0;
      done_b    <= 1'b0;
      busy      <= 1'b0;
      out_vec   <= '0;
    end else begin
      grant_a <= w_take & ~w_pick_b;
      grant_b <= w_take & w_pick_b;
      done_a  <= (r_state == S_DONE) & ~r_owner_b;
      done_b  <= (r_state == S_DONE) & r_owner_b;
      busy    <= (r_state != S_IDLE);
      if (w_take) begin
        r_owner_b <= w_pick_b;
        r_ptr_b   <= ~w_pick_b;
        r_len     <= w_len_clamp;
        r_idx     <= '0;
        for (int i = 0; i < NUM_ELEM; i++) begin
          r_op1[i] <= w_pick_b ? vec1_b[i*WIDTH +: WIDTH] : vec1_a[i*WIDTH +: WIDTH];
          r_op2[i] <= w_pick_b ? vec2_b[i*WIDTH +: WIDTH] : vec2_a[i*WIDTH +: WIDTH];
        end
      end
      if (r_state == S_RUN) begin
        r_idx <= w_idx_next;
        for (int k = 0; k < LANES; k++) r_res[IDX_W'(w_j[k])] <= w_sum[k];
      end
      // Elements beyond the processed range may hold stale data; zero them on publish
      if (r_state == S_DONE) begin
        for (int i = 0; i < NUM_ELEM; i++)
          out_vec[i*WIDTH +: WIDTH] <= (LEN_W'(i) < r_idx) ? r_res[i] : '0;
      end
    end
  end

endmodule

// File: tb/tb_pointwise_add_sched.sv
// Self-checking bench for pointwise_add_sched: random operands vs. an arithmetic reference model.
`timescale 1ns/1ps
module tb_pointwise_add_sched;
  localparam int unsigned W   = 32;
  localparam int unsigned N   = 16;
  localparam int unsigned L   = 4;
  localparam int unsigned LW  = 8;
  localparam int          TMO = 64;
  typedef logic [N*W-1:0] vec_t;

  logic clk = 1'b0, rst_n = 1'b0, req_a = 1'b0, req_b = 1'b0;
  logic [LW-1:0] len_a = '0, len_b = '0;
  vec_t vec1_a = '0, vec2_a = '0, vec1_b = '0, vec2_b = '0;
  logic grant_a, grant_b, done_a, done_b, busy;
  vec_t out_vec;
  int n_cmp = 0, n_err = 0;
  bit ptr_b = 1'b0;

  always #5 clk = ~clk;

  pointwise_add_sched #(.WIDTH(W), .NUM_ELEM(N), .LANES(L), .LEN_W(LW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_a(req_a), .len_a(len_a), .vec1_a(vec1_a), .vec2_a(vec2_a),
    .req_b(req_b), .len_b(len_b), .vec1_b(vec1_b), .vec2_b(vec2_b),
    .grant_a(grant_a), .grant_b(grant_b), .done_a(done_a), .done_b(done_b),
    .busy(busy), .out_vec(out_vec));

  // Reference: signed arithmetic on wide integers, then wrap or clamp
  function automatic logic [W-1:0] ref_elem(input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa, sb, s;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    s  = sa + sb;
`ifdef POINTWISE_ADD_SAT_EN
    if (s > 64'sd2147483647)  s = 64'sd2147483647;
    if (s < -64'sd2147483648) s = -64'sd2147483648;
`endif
    return W'(s);
  endfunction

  function automatic int clamp_len(input int len);
    return (len > N) ? N : len;
  endfunction

  function automatic vec_t ref_vec(input int len, input vec_t v1, input vec_t v2);
    vec_t r;
    r = '0;
    for (int i = 0; i < clamp_len(len); i++) r[i*W +: W] = ref_elem(v1[i*W +: W], v2[i*W +: W]);
    return r;
  endfunction

  function automatic int ref_lat(input int len);
    return (clamp_len(len) + L - 1) / L + 1;
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    for (int i = 0; i < N; i++) v[i*W +: W] = $urandom;
    return v;
  endfunction

  task automatic wait_evt(input int which, output int cyc);
    cyc = -1;
    for (int c = 1; c <= TMO; c++) begin
      @(negedge clk);
      if ((which == 0 && grant_a === 1'b1) || (which == 1 && grant_b === 1'b1) ||
          (which == 2 && done_a === 1'b1)  || (which == 3 && done_b === 1'b1) ||
          (which == 4 && (grant_a === 1'b1 || grant_b === 1'b1))) begin
        cyc = c;
        break;
      end
    end
  endtask

  // Drives one uncontended request from a negedge; returns wait/latency/result observations
  task automatic run_op(input bit sel_b, input int len, input vec_t v1, input vec_t v2,
                        output int g_wait, output int lat, output vec_t res,
                        output bit busy_ok, output bit stable_ok);
    vec_t hold;
    lat = -1; res = '0; busy_ok = 1'b1; stable_ok = 1'b1;
    if (sel_b) begin req_b = 1'b1; len_b = LW'(len); vec1_b = v1; vec2_b = v2; end
    else       begin req_a = 1'b1; len_a = LW'(len); vec1_a = v1; vec2_a = v2; end
    wait_evt(sel_b ? 1 : 0, g_wait);
    req_a = 1'b0; req_b = 1'b0;
    vec1_a = rand_vec(); vec2_a = rand_vec(); vec1_b = rand_vec(); vec2_b = rand_vec();
    if (g_wait < 0) return;
    ptr_b = ~sel_b;
    if (busy !== 1'b0) busy_ok = 1'b0;
    hold = out_vec;
    for (int c = 1; c <= TMO; c++) begin
      @(negedge clk);
      if (busy !== 1'b1) busy_ok = 1'b0;
      if ((sel_b ? done_b : done_a) === 1'b1) begin lat = c; res = out_vec; break; end
      if (out_vec !== hold) stable_ok = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if ({grant_a, grant_b} !== 2'b00) begin n_err++; $display("FAIL reset_grant: got %b want 00", {grant_a, grant_b}); end
    n_cmp++; if ({done_a, done_b} !== 2'b00) begin n_err++; $display("FAIL reset_done: got %b want 00", {done_a, done_b}); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (out_vec !== '0) begin n_err++; $display("FAIL reset_out: got %h want 0", out_vec); end
    rst_n = 1'b1; ptr_b = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    vec_t v1, v2, res; int gw, lat; bit bok, sok;
    v1 = '0; v2 = '0;
    for (int i = 0; i < N; i++) begin v1[i*W +: W] = W'(i); v2[i*W +: W] = W'(100 + i); end
    run_op(1'b0, 8, v1, v2, gw, lat, res, bok, sok);
    n_cmp++; if (gw !== 1) begin n_err++; $display("FAIL basic_grant_wait: got %0d want 1", gw); end
    n_cmp++; if (lat !== 3) begin n_err++; $display("FAIL basic_latency: got %0d want 3", lat); end
    n_cmp++; if (res[7*W +: W] !== 32'd114) begin n_err++; $display("FAIL basic_elem7: got %0d want 114", res[7*W +: W]); end
    n_cmp++; if (res !== ref_vec(8, v1, v2)) begin n_err++; $display("FAIL basic_out: got %h want %h", res, ref_vec(8, v1, v2)); end
    n_cmp++; if (!bok) begin n_err++; $display("FAIL basic_busy: got bad busy window want high t+1..done"); end
    n_cmp++; if (!sok) begin n_err++; $display("FAIL basic_stable: got out_vec change before done want stable"); end
  endtask

  task automatic test_simultaneous();
    vec_t a1, a2, b1, b2; int la, lb, c; bit exp_b;
    a1 = rand_vec(); a2 = rand_vec(); b1 = rand_vec(); b2 = rand_vec();
    la = $urandom_range(1, N); lb = $urandom_range(1, N);
    for (int pair = 0; pair < 2; pair++) begin
      req_a = 1'b1; len_a = LW'(la); vec1_a = a1; vec2_a = a2;
      req_b = 1'b1; len_b = LW'(lb); vec1_b = b1; vec2_b = b2;
      exp_b = ptr_b;
      wait_evt(4, c);
      n_cmp++; if (c < 0 || grant_b !== exp_b || grant_a !== ~exp_b) begin
        n_err++; $display("FAIL sim_first_grant: got a=%b b=%b want b=%b", grant_a, grant_b, exp_b); end
      if (exp_b) req_b = 1'b0; else req_a = 1'b0;
      ptr_b = ~exp_b;
      wait_evt(exp_b ? 3 : 2, c);
      n_cmp++; if (c !== ref_lat(exp_b ? lb : la)) begin n_err++; $display("FAIL sim_first_lat: got %0d want %0d", c, ref_lat(exp_b ? lb : la)); end
      n_cmp++; if (out_vec !== (exp_b ? ref_vec(lb, b1, b2) : ref_vec(la, a1, a2))) begin n_err++; $display("FAIL sim_first_out: got %h", out_vec); end
      wait_evt(exp_b ? 0 : 1, c);
      n_cmp++; if (c !== 1) begin n_err++; $display("FAIL sim_second_grant_gap: got %0d want 1", c); end
      req_a = 1'b0; req_b = 1'b0;
      ptr_b = exp_b;
      wait_evt(exp_b ? 2 : 3, c);
      n_cmp++; if (out_vec !== (exp_b ? ref_vec(la, a1, a2) : ref_vec(lb, b1, b2))) begin n_err++; $display("FAIL sim_second_out: got %h", out_vec); end
    end
  endtask

  task automatic test_back_to_back();
    int c, la, lb, lastlen; bit exp_b, got_b; vec_t a1, a2, b1, b2;
    a1 = rand_vec(); a2 = rand_vec(); b1 = rand_vec(); b2 = rand_vec();
    la = $urandom_range(0, N); lb = $urandom_range(0, N);
    req_a = 1'b1; len_a = LW'(la); vec1_a = a1; vec2_a = a2;
    req_b = 1'b1; len_b = LW'(lb); vec1_b = b1; vec2_b = b2;
    got_b = 1'b0;
    for (int g = 0; g < 6; g++) begin
      exp_b = ptr_b;
      wait_evt(4, c);
      got_b = (grant_b === 1'b1);
      n_cmp++; if (c < 0 || got_b !== exp_b || (grant_a & grant_b) === 1'b1) begin
        n_err++; $display("FAIL b2b_grant%0d: got b=%b want b=%b", g, got_b, exp_b); end
      ptr_b = ~exp_b;
    end
    req_a = 1'b0; req_b = 1'b0;
    lastlen = got_b ? lb : la;
    wait_evt(got_b ? 3 : 2, c);
    n_cmp++; if (out_vec !== (got_b ? ref_vec(lastlen, b1, b2) : ref_vec(lastlen, a1, a2))) begin
      n_err++; $display("FAIL b2b_last_out: got %h", out_vec); end
  endtask

  task automatic test_boundaries();
    vec_t v1, v2, res; int gw, lat; bit bok, sok;
    v1 = rand_vec(); v2 = rand_vec();
    run_op(1'b0, 0, v1, v2, gw, lat, res, bok, sok);
    n_cmp++; if (lat !== 1) begin n_err++; $display("FAIL len0_latency: got %0d want 1", lat); end
    n_cmp++; if (res !== '0) begin n_err++; $display("FAIL len0_out: got %h want 0", res); end
    n_cmp++; if (!bok) begin n_err++; $display("FAIL len0_busy: got bad busy window want high on done"); end
    v1 = rand_vec(); v2 = rand_vec();
    run_op(1'b0, N + 5, v1, v2, gw, lat, res, bok, sok);
    n_cmp++; if (lat !== N / L + 1) begin n_err++; $display("FAIL oversize_latency: got %0d want %0d", lat, N / L + 1); end
    n_cmp++; if (res !== ref_vec(N, v1, v2)) begin n_err++; $display("FAIL oversize_out: got %h want %h", res, ref_vec(N, v1, v2)); end
  endtask

  task automatic test_partial();
    vec_t v1, v2, res; int gw, lat; bit bok, sok;
    v1 = rand_vec(); v2 = rand_vec();
    run_op(1'b1, 6, v1, v2, gw, lat, res, bok, sok);
    n_cmp++; if (lat !== 3) begin n_err++; $display("FAIL partial_latency: got %0d want 3", lat); end
    n_cmp++; if (res !== ref_vec(6, v1, v2)) begin n_err++; $display("FAIL partial_out: got %h want %h", res, ref_vec(6, v1, v2)); end
    n_cmp++; if (res[N*W-1:6*W] !== '0) begin n_err++; $display("FAIL partial_tail: got %h want 0", res[N*W-1:6*W]); end
  endtask

  task automatic test_overflow();
    vec_t v1, v2, res; int gw, lat; bit bok, sok;
    logic [W-1:0] e0, e1;
`ifdef POINTWISE_ADD_SAT_EN
    e0 = 32'h7FFF_FFFF; e1 = 32'h8000_0000;
`else
    e0 = 32'h8000_0000; e1 = 32'h7FFF_FFFF;
`endif
    v1 = rand_vec(); v2 = rand_vec();
    v1[0 +: W] = 32'h7FFF_FFFF; v2[0 +: W] = 32'h0000_0001;
    v1[W +: W] = 32'h8000_0000; v2[W +: W] = 32'hFFFF_FFFF;
    run_op(1'b0, 2, v1, v2, gw, lat, res, bok, sok);
    n_cmp++; if (res[0 +: W] !== e0) begin n_err++; $display("FAIL ovf_pos: got %h want %h", res[0 +: W], e0); end
    n_cmp++; if (res[W +: W] !== e1) begin n_err++; $display("FAIL ovf_neg: got %h want %h", res[W +: W], e1); end
    n_cmp++; if (res[N*W-1:2*W] !== '0) begin n_err++; $display("FAIL ovf_tail: got %h want 0", res[N*W-1:2*W]); end
  endtask

  task automatic test_reset_mid_run();
    vec_t v1, v2, res; int c, pulses, gw, lat, len; bit bok, sok;
    req_a = 1'b1; len_a = LW'(N); vec1_a = rand_vec(); vec2_a = rand_vec();
    wait_evt(0, c);
    req_a = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy: got %b want 0", busy); end
    n_cmp++; if (out_vec !== '0) begin n_err++; $display("FAIL midrst_out: got %h want 0", out_vec); end
    rst_n = 1'b1; ptr_b = 1'b0;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done_a === 1'b1 || done_b === 1'b1 || busy === 1'b1) pulses++;
    end
    n_cmp++; if (pulses !== 0) begin n_err++; $display("FAIL midrst_no_done: got %0d activity cycles want 0", pulses); end
    v1 = rand_vec(); v2 = rand_vec(); len = $urandom_range(1, N);
    run_op(1'b1, len, v1, v2, gw, lat, res, bok, sok);
    n_cmp++; if (lat !== ref_lat(len) || res !== ref_vec(len, v1, v2)) begin
      n_err++; $display("FAIL midrst_fresh: got lat %0d want %0d", lat, ref_lat(len)); end
  endtask

  task automatic test_random();
    vec_t v1, v2, res; int gw, lat, len; bit sel, bok, sok;
    for (int t = 0; t < 24; t++) begin
      sel = 1'($urandom_range(0, 1));
      len = $urandom_range(0, N + 5);
      v1 = rand_vec(); v2 = rand_vec();
      run_op(sel, len, v1, v2, gw, lat, res, bok, sok);
      n_cmp++; if (gw !== 1 || lat !== ref_lat(len)) begin
        n_err++; $display("FAIL rand%0d_timing: got wait %0d lat %0d want 1 %0d", t, gw, lat, ref_lat(len)); end
      n_cmp++; if (res !== ref_vec(len, v1, v2)) begin
        n_err++; $display("FAIL rand%0d_out: len %0d got %h want %h", t, len, res, ref_vec(len, v1, v2)); end
      n_cmp++; if (!bok || !sok) begin n_err++; $display("FAIL rand%0d_busy_stable: got busy %b stable %b want 1 1", t, bok, sok); end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_simultaneous();
    test_back_to_back();
    test_boundaries();
    test_partial();
    test_overflow();
    test_reset_mid_run();
    test_random();
    test_simultaneous();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pointwise_add_sched.md
Name: pointwise_add_sched

Overview:
- Time-multiplexed vector-add engine with a two-requester round-robin arbiter.
- Requester A is the forward-pass bias add; requester B is the weight/bias update path.
- Instead of a full-width bank of fixed-point adders, it processes LANES elements per cycle over an operand vector of up to NUM_ELEM elements.
- Holds the result vector stable until the next operation completes.

Parameters:
- WIDTH, 32: fixed-point element width, two's complement.
- NUM_ELEM, `MAX_NEURONS: vector length capacity in elements.
- LANES, 4: adders instantiated, i.e. elements processed per RUN cycle. Must divide NUM_ELEM.
- LEN_W, 8: width of the length inputs. 2^LEN_W must be greater than NUM_ELEM.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- req_a  in  1  requester A operation request.
- len_a  in  LEN_W  requester A valid element count.
- vec1_a  in  NUM_ELEM*WIDTH  requester A operand 1, element i at [i*WIDTH +: WIDTH].
- vec2_a  in  NUM_ELEM*WIDTH  requester A operand 2.
- req_b, len_b, vec1_b, vec2_b  in  same widths as A  requester B equivalents.
- grant_a  out  1  one-cycle pulse; A's operands were latched this cycle.
- grant_b  out  1  one-cycle pulse; B's operands were latched this cycle.
- done_a  out  1  one-cycle pulse; A's result is valid on out_vec.
- done_b  out  1  one-cycle pulse; B's result is valid on out_vec.
- busy  out  1  high when the state is not IDLE.
- out_vec  out  NUM_ELEM*WIDTH  result vector, registered.

Behaviour:
- Decided interface: one clock (clk); reset rst_n is synchronous and active-low.
- Reset (rst_n=0 at a clk edge):
  - state=IDLE; all grant/done outputs low; busy low; out_vec all zero.
  - Internal element index=0; round-robin pointer favours A.
  - An operation in progress is abandoned; no done pulse is issued.
- States: IDLE, RUN, DONE.
- IDLE:
  - Exactly one req high: grant it.
  - Both high: grant the side the pointer favours, then point the pointer at the other side.
  - On grant: latch vec1/vec2/len of the winner, plus owner id, into operand registers. Pulse grant_x. Clear idx=0. Go to RUN, or to DONE if len=0.
  - No req: stay in IDLE.
- Length clamp: a latched len greater than NUM_ELEM is clamped to NUM_ELEM.
- RUN, each cycle:
  - Lanes k=0..LANES-1 compute element j=idx+k.
  - If j<len: result_reg[j] = op1[j]+op2[j], truncated to WIDTH bits (wrap).
  - If j>=len: result_reg[j] = 0.
  - idx += LANES. When the new idx >= len, go to DONE.
- DONE:
  - Any elements at or beyond the processed range are zero-filled.
  - out_vec is loaded from result_reg; done_<owner> pulses for one cycle.
  - Go to IDLE. The next grant can occur on the following IDLE cycle, not in the same cycle as DONE.
- Latency: grant cycle → done pulse = ceil(len/LANES)+1 cycles. With len=0, done follows the grant by 1 cycle.
- Request hold rule:
  - A requester holds req until it sees its grant. Operands are needed only in the grant cycle.
  - req dropping after grant does not affect the operation in progress.
  - req still high after done is treated as a new request.
- Stability: out_vec changes only in the DONE cycle and at reset.
- busy is high from the cycle after grant through DONE, inclusive.
- Pending requests: a request arriving while busy waits. Fairness: under continuous A and B requests, grants strictly alternate.

Optional Feature:
- Macro: POINTWISE_ADD_SAT_EN.
- Defined: each lane saturates. Positive overflow yields 0x7FFF_FFFF; negative overflow yields 0x8000_0000, scaled to WIDTH.
- Undefined: two's-complement wrap, as described in Behaviour.
- Timing is identical in both builds.

Test Plan:
- Basic add, no contention:
  - Stimulus: reset; req_a with len_a=8, LANES=4; vec1[i]=i, vec2[i]=100+i.
  - Response: grant_a at cycle t; done_a at t+3; out_vec[i]=100+2i for i<8, else 0; busy high for t+1..t+3.
- Simultaneous requests:
  - Stimulus: req_a and req_b high together after reset.
  - Response: A granted first, then B after A's DONE; out_vec holds B's result on done_b; a third simultaneous pair is granted to A.
- Boundaries:
  - Stimulus: len_a=0, then len_a=NUM_ELEM+5.
  - Response: for len 0, done_a one cycle after grant with out_vec all zero; for the oversized len, all NUM_ELEM elements are summed and latency is NUM_ELEM/LANES+1.
- Partial final chunk:
  - Stimulus: len=6, LANES=4.
  - Response: elements 0–5 are sums; elements 6.. are zero; two RUN cycles.
- Reset mid-RUN:
  - Stimulus: assert rst_n=0 during the second RUN cycle.
  - Response: next cycle is IDLE, out_vec=0, no done pulse; a fresh request completes normally.
- Overflow:
  - Stimulus: 0x7FFF_FFFF + 0x0000_0001.
  - Response: 0x8000_0000 without the macro; 0x7FFF_FFFF with POINTWISE_ADD_SAT_EN.
  - Stimulus: 0x8000_0000 + 0xFFFF_FFFF.
  - Response: 0x7FFF_FFFF without the macro; 0x8000_0000 with it.
